// File: rtl/frame_strobe_ctrl_pkg.sv
// Shared definitions for the column frame-strobe controller.
// Contents:
//   state_e       - controller phase (IDLE/SETUP/STROBE/HOLD)
//   COL_*/FRAME_* - bit positions of the column select and frame index in FrameAddr
//   BROADCAST_COL - column code that addresses every column when broadcast is enabled
//   cnt_width()   - width of the phase down-counter for a given set of phase lengths
package frame_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int COL_MSB       = 31;
  localparam int COL_LSB       = 27;
  localparam int FRAME_IDX_MSB = 4;
  localparam int FRAME_IDX_LSB = 0;

  localparam logic [4:0] BROADCAST_COL = 5'b11111;

  // clog2(max(a,b,c)+1), never less than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/frame_strobe_ctrl_if.sv
// Request/strobe bundle between the configuration word loader and one
// column's frame-strobe controller.
// Signals:
//   FrameAddr   - [31:27] column select, [4:0] frame index
//   req_valid   - request present, FrameAddr valid while high
//   req_ready   - controller idle; a transfer happens on req_valid && req_ready
//   FrameStrobe - registered one-hot strobe to the column terminal tile
//   busy        - controller is in any phase other than IDLE
//   err         - one-cycle pulse after an in-column request with a bad frame index
//   state       - current controller phase, for observation
// Modports: master = loader side, slave = controller side.
interface frame_strobe_ctrl_if #(
  parameter int MaxFramesPerCol = 20
);
  import frame_cfg_pkg::*;

  logic [31:0]                FrameAddr;
  logic                       req_valid;
  logic                       req_ready;
  logic [MaxFramesPerCol-1:0] FrameStrobe;
  logic                       busy;
  logic                       err;
  state_e                     state;

  modport master (
    output FrameAddr, req_valid,
    input  req_ready, FrameStrobe, busy, err, state
  );

  modport slave (
    input  FrameAddr, req_valid,
    output req_ready, FrameStrobe, busy, err, state
  );
endinterface

// File: rtl/frame_strobe_ctrl_phase_timer.sv
// frame_phase_timer: loadable down-counter shared by the SETUP, STROBE and
// HOLD phases. A load takes priority; otherwise the count decrements and
// parks at zero.
// Ports:
//   clk, reset - clock and synchronous active-high reset (count -> 0)
//   load       - load load_val this cycle
//   load_val   - value to load
//   count      - current count
//   zero       - count == 0
module frame_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/frame_strobe_ctrl.sv
// frame_strobe_ctrl: column-level frame-strobe generator feeding the
// terminal tile of one fabric column. Accepts a frame-write request, checks
// the column select against Col, and emits a one-hot FrameStrobe pulse with
// SetupCycles of lead-in and HoldCycles of spacing after it.
// Ports:
//   CLK   - configuration clock
//   reset - synchronous active-high reset; truncates any in-flight strobe
//   bus   - frame_strobe_ctrl_if.slave (request handshake, strobe, status)
// Handshake: a request transfers on the rising edge where req_valid and
//   req_ready are both high; req_ready is high exactly in IDLE, and
//   req_valid/FrameAddr are ignored at any other time.
// Build option: FRAME_STROBE_BROADCAST_EN makes column code 5'b11111 match
//   every instance; without it that code matches nothing.
module frame_strobe_ctrl
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5,
  parameter int Col              = 0,
  parameter int SetupCycles      = 1,
  parameter int StrobeCycles     = 1,
  parameter int HoldCycles       = 1
) (
  input logic                CLK,
  input logic                reset,
  frame_strobe_ctrl_if.slave bus
);

  localparam int CW = cnt_width(SetupCycles, StrobeCycles, HoldCycles);

  // The timer reaches zero in the last cycle of a phase, so each phase
  // loads its length minus one.
  localparam logic [CW-1:0] SETUP_LD  = CW'((SetupCycles > 0) ? SetupCycles - 1 : 0);
  localparam logic [CW-1:0] STROBE_LD = CW'(StrobeCycles - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'((HoldCycles > 0) ? HoldCycles - 1 : 0);

  state_e                     state_q, state_n;
  logic [4:0]                 idx_q, idx_n;
  logic                       err_q, err_n;
  logic [MaxFramesPerCol-1:0] strobe_q;

  logic                        tmr_load;
  logic [CW-1:0]               tmr_val;
  logic [CW-1:0]               tmr_count_unused;
  logic                        tmr_zero;

  logic                        hs;
  logic [FrameSelectWidth-1:0] col_field;
  logic [4:0]                  idx_field;
  logic                        col_hit;
  logic                        idx_ok;
  logic                        unused_addr_bits;

  assign hs        = bus.req_valid && (state_q == IDLE);
  assign col_field = bus.FrameAddr[COL_MSB:COL_LSB];
  assign idx_field = bus.FrameAddr[FRAME_IDX_MSB:FRAME_IDX_LSB];
  assign idx_ok    = (32'(idx_field) < 32'(MaxFramesPerCol));
  assign unused_addr_bits = ^bus.FrameAddr[COL_LSB-1:FRAME_IDX_MSB+1];

`ifdef FRAME_STROBE_BROADCAST_EN
  assign col_hit = (col_field == FrameSelectWidth'(Col)) || (col_field == BROADCAST_COL);
`else
  // The broadcast code is reserved, so it must not match even an instance
  // built with Col=31.
  assign col_hit = (col_field == FrameSelectWidth'(Col)) && (col_field != BROADCAST_COL);
`endif

  frame_phase_timer #(.W(CW)) u_timer (
    .clk      (CLK),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count_unused),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    err_n    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          idx_n = idx_field;
          if (col_hit) begin
            if (!idx_ok) begin
              err_n = 1'b1;
            end else if (SetupCycles > 0) begin
              state_n  = SETUP;
              tmr_load = 1'b1;
              tmr_val  = SETUP_LD;
            end else begin
              state_n  = STROBE;
              tmr_load = 1'b1;
              tmr_val  = STROBE_LD;
            end
          end
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          state_n  = STROBE;
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end
      end
      STROBE: begin
        if (tmr_zero) begin
          if (HoldCycles > 0) begin
            state_n  = HOLD;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      HOLD: begin
        if (tmr_zero) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      err_q    <= 1'b0;
      strobe_q <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      err_q   <= err_n;
      // Strobe is registered from the next state so it is high exactly
      // during the STROBE cycles and can never glitch.
      if (state_n == STROBE) strobe_q <= {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << idx_n;
      else                   strobe_q <= '0;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.err         = err_q;
  assign bus.FrameStrobe = strobe_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_frame_strobe_ctrl.sv
// Directed bench for frame_strobe_ctrl with three instances:
//   u0: defaults (Col=0, 1/1/1 phases)
//   u1: Col=0, SetupCycles=0, StrobeCycles=3, HoldCycles=0
//   u2: Col=7, default phases (broadcast partner of u0)
// Build option: FRAME_STROBE_BROADCAST_EN selects the broadcast expectations.
module tb_frame_strobe_ctrl;
  import frame_cfg_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  frame_strobe_ctrl_if #(.MaxFramesPerCol(20)) bus0 ();
  frame_strobe_ctrl_if #(.MaxFramesPerCol(20)) bus1 ();
  frame_strobe_ctrl_if #(.MaxFramesPerCol(20)) bus2 ();

  frame_strobe_ctrl #(.Col(0)) u0 (.CLK(clk), .reset(rst), .bus(bus0.slave));
  frame_strobe_ctrl #(.Col(0), .SetupCycles(0), .StrobeCycles(3), .HoldCycles(0))
    u1 (.CLK(clk), .reset(rst), .bus(bus1.slave));
  frame_strobe_ctrl #(.Col(7)) u2 (.CLK(clk), .reset(rst), .bus(bus2.slave));

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one cycle: outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] bc_strobe;
    logic [31:0] bc_busy;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus0.FrameAddr = '0; bus0.req_valid = 1'b0;
    bus1.FrameAddr = '0; bus1.req_valid = 1'b0;
    bus2.FrameAddr = '0; bus2.req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_ready", 32'(bus0.req_ready), 32'd1);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_err", 32'(bus0.err), 32'd0);
    check("rst_strobe", 32'(bus0.FrameStrobe), 32'd0);
    check("rst_state", 32'(bus0.state), 32'(IDLE));
    check("rst_strobe_u1", 32'(bus1.FrameStrobe), 32'd0);

    // default timing, index 3
    bus0.FrameAddr = 32'h0000_0003; bus0.req_valid = 1'b1;
    check("d_ready_t", 32'(bus0.req_ready), 32'd1);
    tick(); // t+1
    bus0.req_valid = 1'b0;
    check("d_ready_t1", 32'(bus0.req_ready), 32'd0);
    check("d_busy_t1", 32'(bus0.busy), 32'd1);
    check("d_strobe_t1", 32'(bus0.FrameStrobe), 32'd0);
    check("d_state_t1", 32'(bus0.state), 32'(SETUP));
    tick(); // t+2
    check("d_strobe_t2", 32'(bus0.FrameStrobe), 32'h00008);
    check("d_ready_t2", 32'(bus0.req_ready), 32'd0);
    tick(); // t+3
    check("d_strobe_t3", 32'(bus0.FrameStrobe), 32'd0);
    check("d_ready_t3", 32'(bus0.req_ready), 32'd0);
    check("d_state_t3", 32'(bus0.state), 32'(HOLD));
    tick(); // t+4
    check("d_ready_t4", 32'(bus0.req_ready), 32'd1);
    check("d_busy_t4", 32'(bus0.busy), 32'd0);

    // column 1 request: dropped silently
    bus0.FrameAddr = 32'h0800_0005; bus0.req_valid = 1'b1;
    tick();
    bus0.req_valid = 1'b0;
    check("mis_ready", 32'(bus0.req_ready), 32'd1);
    check("mis_busy", 32'(bus0.busy), 32'd0);
    check("mis_err", 32'(bus0.err), 32'd0);
    check("mis_strobe1", 32'(bus0.FrameStrobe), 32'd0);
    tick();
    check("mis_strobe2", 32'(bus0.FrameStrobe), 32'd0);
    check("mis_busy2", 32'(bus0.busy), 32'd0);

    // index 20: err pulse only
    bus0.FrameAddr = 32'h0000_0014; bus0.req_valid = 1'b1;
    tick();
    bus0.req_valid = 1'b0;
    check("oor_err_t1", 32'(bus0.err), 32'd1);
    check("oor_strobe_t1", 32'(bus0.FrameStrobe), 32'd0);
    check("oor_busy_t1", 32'(bus0.busy), 32'd0);
    tick();
    check("oor_err_t2", 32'(bus0.err), 32'd0);
    check("oor_strobe_t2", 32'(bus0.FrameStrobe), 32'd0);

    // u1: index 19 with no setup/hold, then a held request for index 1
    bus1.FrameAddr = 32'h0000_0013; bus1.req_valid = 1'b1;
    tick(); // t+1
    bus1.FrameAddr = 32'h0000_0001;
    check("s0_strobe_t1", 32'(bus1.FrameStrobe), 32'h80000);
    check("s0_ready_t1", 32'(bus1.req_ready), 32'd0);
    tick(); // t+2
    check("s0_strobe_t2", 32'(bus1.FrameStrobe), 32'h80000);
    tick(); // t+3
    check("s0_strobe_t3", 32'(bus1.FrameStrobe), 32'h80000);
    tick(); // t+4: idle, held request accepted here
    check("s0_strobe_t4", 32'(bus1.FrameStrobe), 32'd0);
    check("s0_ready_t4", 32'(bus1.req_ready), 32'd1);
    check("s0_state_t4", 32'(bus1.state), 32'(IDLE));
    tick(); // t+5
    bus1.req_valid = 1'b0;
    check("s0_next_t5", 32'(bus1.FrameStrobe), 32'h00002);
    tick();
    check("s0_next_t6", 32'(bus1.FrameStrobe), 32'h00002);
    tick();
    check("s0_next_t7", 32'(bus1.FrameStrobe), 32'h00002);
    tick();
    check("s0_next_t8", 32'(bus1.FrameStrobe), 32'd0);
    check("s0_ready_t8", 32'(bus1.req_ready), 32'd1);

    // reset in the first strobe cycle truncates the pulse
    bus1.FrameAddr = 32'h0000_0005; bus1.req_valid = 1'b1;
    tick(); // first strobe cycle
    bus1.req_valid = 1'b0;
    check("rs_strobe_on", 32'(bus1.FrameStrobe), 32'h00020);
    check("rs_state_on", 32'(bus1.state), 32'(STROBE));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_strobe_off", 32'(bus1.FrameStrobe), 32'd0);
    check("rs_state_off", 32'(bus1.state), 32'(IDLE));
    check("rs_ready", 32'(bus1.req_ready), 32'd1);
    tick();
    check("rs_strobe_after", 32'(bus1.FrameStrobe), 32'd0);

    // broadcast column code to Col=0 and Col=7
`ifdef FRAME_STROBE_BROADCAST_EN
    bc_strobe = 32'h00004;
    bc_busy   = 32'd1;
`else
    bc_strobe = 32'd0;
    bc_busy   = 32'd0;
`endif
    bus0.FrameAddr = 32'hF800_0002; bus0.req_valid = 1'b1;
    bus2.FrameAddr = 32'hF800_0002; bus2.req_valid = 1'b1;
    tick();
    bus0.req_valid = 1'b0;
    bus2.req_valid = 1'b0;
    check("bc_busy_c0", 32'(bus0.busy), bc_busy);
    check("bc_busy_c7", 32'(bus2.busy), bc_busy);
    tick();
    check("bc_strobe_c0", 32'(bus0.FrameStrobe), bc_strobe);
    check("bc_strobe_c7", 32'(bus2.FrameStrobe), bc_strobe);
    check("bc_err_c0", 32'(bus0.err), 32'd0);
    tick();
    tick();
    check("bc_ready_c7", 32'(bus2.req_ready), 32'd1);

    // Col=7 normal request, index 1
    bus2.FrameAddr = 32'h3800_0001; bus2.req_valid = 1'b1;
    tick();
    bus2.req_valid = 1'b0;
    tick();
    check("c7_strobe", 32'(bus2.FrameStrobe), 32'h00002);
    check("c7_other_col", 32'(bus0.FrameStrobe), 32'd0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_strobe_ctrl.md
Name: frame_strobe_ctrl

Overview:
Column-level frame-strobe generator that sits directly upstream of the terminal tile at the bottom of each fabric column. It produces the FrameStrobe bus that the tile buffers and forwards up the column.
- Accepts frame-write requests from the configuration word loader.
- Decodes column and frame index from the request address.
- Emits a timed one-hot FrameStrobe pulse with setup and hold spacing around it, so the FrameData latched in each tile's config cells is stable.

Parameters:
MaxFramesPerCol, 20, width of FrameStrobe, i.e. frames per column
FrameSelectWidth, 5, width of column-select field FrameAddr[31:27]
Col, 0, column index this instance answers to (0..30; 31 is reserved)
SetupCycles, 1, idle cycles between accept and strobe assertion (0 allowed)
StrobeCycles, 1, cycles FrameStrobe stays high (must be >=1)
HoldCycles, 1, cycles after strobe deassertion before the next request is accepted (0 allowed)

Ports:
CLK  input  1  configuration clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
FrameAddr  input  32  [31:27] column select, [4:0] frame index, other bits ignored
req_valid  input  1  request present; FrameAddr is valid while this is high
req_ready  output  1  high only in IDLE; handshake completes on req_valid && req_ready
FrameStrobe  output  MaxFramesPerCol  registered one-hot strobe to the column terminal tile
busy  output  1  high in any state other than IDLE
err  output  1  one-cycle pulse, the cycle after a matching request whose frame index is >= MaxFramesPerCol

Behaviour:
- States: IDLE, SETUP, STROBE, HOLD.
- Reset values: state=IDLE, FrameStrobe=0, busy=0, err=0, req_ready=1 (follows IDLE), counter=0, latched index=0.
- IDLE, on handshake (cycle t), FrameAddr is latched.
  - Column mismatch: the request is consumed and dropped. Stay in IDLE; no strobe, no err.
  - Column match with index >= MaxFramesPerCol: err=1 at t+1. Stay in IDLE; no strobe.
  - Column match with valid index: go to SETUP and load counter with SetupCycles. If SetupCycles=0, go straight to STROBE.
- SETUP: decrement each cycle; at counter==0, go to STROBE.
- STROBE: FrameStrobe[idx]=1, all other bits 0, for exactly StrobeCycles cycles.
  - The first high cycle is t+1+SetupCycles.
  - Go to HOLD with counter=HoldCycles, or to IDLE if HoldCycles=0.
- HOLD: FrameStrobe=0; count down, then IDLE.
- Throughput with a continuous valid stream is one strobe per 1+SetupCycles+StrobeCycles+HoldCycles cycles.
- req_valid and FrameAddr are ignored outside IDLE. A request held across busy cycles is accepted on the first IDLE cycle.
- reset asserted in any state: at the next edge, FrameStrobe=0 and state=IDLE. Any in-flight strobe is truncated, not completed.
- No two FrameStrobe bits are ever high in the same cycle. No glitch: the output is registered.
- Counter width is clog2(max(SetupCycles,StrobeCycles,HoldCycles)+1), with a minimum of 1.

Optional Feature:
FRAME_STROBE_BROADCAST_EN
- Defined: a column field of 5'b11111 matches every instance. All columns strobe the same frame in lockstep (bulk clear/fill). err follows the normal index check.
- Undefined: 5'b11111 matches no instance. Requests carrying it are consumed and dropped like any other mismatch.

Decomposition:
- Package frame_cfg_pkg:
  - state enum (IDLE/SETUP/STROBE/HOLD);
  - field positions COL_MSB=31 and COL_LSB=27, FRAME_IDX_MSB=4 and FRAME_IDX_LSB=0;
  - BROADCAST_COL=5'b11111.
- One sub-module, frame_phase_timer: loadable down-counter with a zero flag, reused for the SETUP, STROBE and HOLD phases.

Test Plan:
- Defaults, Col=0, FrameAddr=32'h0000_0003 with valid at t: FrameStrobe=20'h00008 during t+2 only; req_ready low t+1..t+3, high at t+4.
- Col=0, FrameAddr=32'h0800_0005 (column 1): no strobe, err=0, req_ready stays high, busy stays 0.
- FrameAddr=32'h0000_0014 (index 20): err=1 at t+1 only; FrameStrobe stays 0.
- SetupCycles=0, StrobeCycles=3, HoldCycles=0, index 19: FrameStrobe=20'h80000 for t+1..t+3; the next held request is accepted at t+4.
- reset pulsed in the first STROBE cycle with StrobeCycles=3: FrameStrobe=0 the next cycle, state IDLE, req_ready=1.
- FRAME_STROBE_BROADCAST_EN defined, FrameAddr=32'hF800_0002, instances Col=0 and Col=7: both give FrameStrobe=20'h00004 on the same cycle. Macro undefined: neither strobes.
